steer_cntrl: RTL and testbench
==============================

STEER_CNTRL -- requirements
Module: steer_cntrl

Interface
REQ-001 SHALL have parameter KP, default 4, unsigned 3-bit proportional gain.
REQ-002 SHALL have parameter KD, default 8, unsigned 4-bit derivative gain.
REQ-003 SHALL have parameter BASE_SPD, default 10'h200, target forward speed magnitude.
REQ-004 SHALL have parameter RAMP_STEP, default 10'h040, base-speed increment per accepted sample.
REQ-005 SHALL have ports: clk  input  1  single clock; rising edge active.
REQ-006 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: go  input  1  level enable; low forces brake.
REQ-008 SHALL have ports: err_vld  input  1  one-cycle strobe qualifying error.
REQ-009 SHALL have ports: error  input  12  signed two's-complement line-position error.
REQ-010 SHALL have ports: lft, rht  output  11 each  motor command; bit 10 = reverse, [9:0] = magnitude; 11'h000 = brake.
REQ-011 SHALL have ports: cmd_vld  output  1  one-cycle pulse when lft/rht update.
REQ-012 SHALL have ports: busy  output  1  high while the FSM is not IDLE.

Function
REQ-013 SHALL use FSM states IDLE, PTERM, DTERM, SUM, MIX; IDLE->PTERM on err_vld&go; others advance unconditionally; MIX->IDLE.
REQ-014 SHALL on err_vld&go in IDLE latch error and set frc = min(frc+RAMP_STEP, BASE_SPD).
REQ-015 SHALL compute PTERM: p = error*KP, 18-bit signed, unsaturated.
REQ-016 SHALL compute DTERM: d = (error - prev_err)*KD, 18-bit signed; prev_err <= error.
REQ-017 SHALL compute SUM: steer = p+d saturated to [-1023, +1023].
REQ-018 SHALL compute MIX: lft_s = frc+steer, rht_s = frc-steer, each saturated to [-1023, +1023].
REQ-019 SHALL register lft/rht at MIX exit in sign-magnitude form and pulse cmd_vld in that cycle; zero encodes as 11'h000, never 11'h400.
REQ-020 SHALL give a fixed latency of 4 clocks from the err_vld edge to the cmd_vld edge.
REQ-021 SHALL drop err_vld while busy, with no effect on frc, prev_err or the computation in flight.
REQ-022 SHALL on go low abort any computation to IDLE, with no cmd_vld; the next cycle SHALL clear lft, rht, frc and prev_err to 0.
REQ-023 SHALL hold lft/rht between updates.

Reset
REQ-024 SHALL on rst asynchronously set lft=0, rht=0, cmd_vld=0, busy=0, frc=0, prev_err=0, state=IDLE.
REQ-025 SHALL let rst mid-computation abandon the sample with no cmd_vld.

Configuration
REQ-026 SHALL, with macro STEER_DTERM_EN defined, include the derivative term per REQ-016.
REQ-027 SHALL, without STEER_DTERM_EN, force d=0 while still updating prev_err; DTERM state and 4-cycle latency SHALL be retained.

Structure
REQ-028 SHALL place the state enum, the widths (ERR_W=12, CMD_W=11, ACC_W=18) and the default KP/KD/BASE_SPD/RAMP_STEP in package steer_pkg.
REQ-029 SHALL implement saturation to ±1023 and sign-magnitude conversion in one sub-module sgn_mag_cnv, instantiated once per side.

Verification
REQ-030 SHALL verify: rst pulse -> lft=rht=11'h000, cmd_vld=0, busy=0.
REQ-031 SHALL verify: go=1, ten err_vld with error=0 -> lft=rht = 0x040, 0x080 ... 0x200, then holding 0x200; each cmd_vld 4 clocks after its strobe.
REQ-032 SHALL verify: after ramp, with prev=0, error=+16 -> lft=0x2C0, rht=0x140; a repeated +16 -> lft=0x240, rht=0x1C0.
REQ-033 SHALL verify: error=-512 with prev=+16 -> lft=11'h5FF, rht=11'h3FF (saturation).
REQ-034 SHALL verify: err_vld 2 clocks after an accepted strobe -> dropped, with exactly one cmd_vld; go low in SUM -> no cmd_vld, and lft=rht=0 next cycle.
REQ-035 SHALL verify: STEER_DTERM_EN undefined, with ramped frc and error=+16 -> lft=0x240, rht=0x1C0.

Source files
------------

// File: rtl/steer_pkg.sv
// Shared types, widths and default tuning for the line-following steering controller.
// Holds the saturation helper used by both the SUM stage and the output converters.
package steer_pkg;

    localparam int ERR_W = 12;
    localparam int CMD_W = 11;
    localparam int ACC_W = 18;
    localparam int MAG_W = CMD_W - 1;

    localparam logic [2:0]       KP_DEF        = 3'd4;
    localparam logic [3:0]       KD_DEF        = 4'd8;
    localparam logic [MAG_W-1:0] BASE_SPD_DEF  = 10'h200;
    localparam logic [MAG_W-1:0] RAMP_STEP_DEF = 10'h040;

    typedef enum logic [2:0] {
        IDLE,
        PTERM,
        DTERM,
        SUM,
        MIX
    } state_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t SAT_HI = 18'sd1023;
    localparam acc_t SAT_LO = -18'sd1023;

    // Symmetric clip keeps -1024 out, so every value has a sign-magnitude encoding.
    function automatic acc_t sat_cmd(input acc_t v);
        if (v > SAT_HI)
            return SAT_HI;
        else if (v < SAT_LO)
            return SAT_LO;
        else
            return v;
    endfunction

endpackage

// File: rtl/sgn_mag_cnv.sv
// Clips a signed wheel speed to +/-1023 and encodes it as {reverse, magnitude}.
// Zero always encodes as all-zero (brake), never as negative zero.
module sgn_mag_cnv
    import steer_pkg::*;
(
    input  acc_t             val,
    output logic [CMD_W-1:0] cmd
);

    acc_t             sat_v;
    logic [MAG_W-1:0] abs_v;

    always_comb begin
        sat_v = sat_cmd(val);
        abs_v = sat_v[ACC_W-1] ? MAG_W'(-sat_v) : MAG_W'(sat_v);
        cmd   = {sat_v[ACC_W-1], abs_v};
    end

endmodule

// File: rtl/steer_cntrl.sv
// PD steering controller: one error sample in, differential left/right motor command out.
// Define STEER_DTERM_EN to enable the derivative term; otherwise d is forced to zero.
module steer_cntrl
    import steer_pkg::*;
#(
    parameter logic [2:0]       KP        = KP_DEF,
    parameter logic [3:0]       KD        = KD_DEF,
    parameter logic [MAG_W-1:0] BASE_SPD  = BASE_SPD_DEF,
    parameter logic [MAG_W-1:0] RAMP_STEP = RAMP_STEP_DEF
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    output logic [CMD_W-1:0]        lft,
    output logic [CMD_W-1:0]        rht,
    output logic                    cmd_vld,
    output logic                    busy
);

    localparam acc_t KP_X = {{(ACC_W-3){1'b0}}, KP};
`ifdef STEER_DTERM_EN
    localparam acc_t KD_X = {{(ACC_W-4){1'b0}}, KD};
`else
    // prev_err still tracks samples so enabling the D term later needs no datapath change.
    localparam acc_t KD_X = '0;
`endif

    state_t state, state_nxt;
    logic   accept, load_cmd, clear;

    logic signed [ERR_W-1:0] err_q, prev_err;
    logic [MAG_W-1:0]        frc, frc_nxt;
    logic [MAG_W:0]          frc_sum;
    acc_t                    p_term, d_term, steer;
    acc_t                    err_x, diff_x, frc_x, lft_s, rht_s;
    logic [CMD_W-1:0]        lft_cmd, rht_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!go) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (err_vld) state_nxt = PTERM;
                PTERM:   state_nxt = DTERM;
                DTERM:   state_nxt = SUM;
                SUM:     state_nxt = MIX;
                MIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && go && err_vld;
        load_cmd = (state == MIX) && go;
        clear    = !go;
    end

    always_comb begin
        frc_sum = {1'b0, frc} + {1'b0, RAMP_STEP};
        frc_nxt = (frc_sum > {1'b0, BASE_SPD}) ? BASE_SPD : frc_sum[MAG_W-1:0];
        err_x   = {{(ACC_W-ERR_W){err_q[ERR_W-1]}}, err_q};
        diff_x  = err_x - {{(ACC_W-ERR_W){prev_err[ERR_W-1]}}, prev_err};
        frc_x   = {{(ACC_W-MAG_W){1'b0}}, frc};
        lft_s   = frc_x + steer;
        rht_s   = frc_x - steer;
    end

    sgn_mag_cnv u_cnv_lft (.val(lft_s), .cmd(lft_cmd));
    sgn_mag_cnv u_cnv_rht (.val(rht_s), .cmd(rht_cmd));

    // Dropping go acts as a brake: outputs, ramp and history all return to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= '0;
            prev_err <= '0;
            frc      <= '0;
            p_term   <= '0;
            d_term   <= '0;
            steer    <= '0;
            lft      <= '0;
            rht      <= '0;
            cmd_vld  <= 1'b0;
        end else if (clear) begin
            prev_err <= '0;
            frc      <= '0;
            lft      <= '0;
            rht      <= '0;
            cmd_vld  <= 1'b0;
        end else begin
            cmd_vld <= load_cmd;
            if (accept) begin
                err_q <= error;
                frc   <= frc_nxt;
            end
            if (state == PTERM)
                p_term <= err_x * KP_X;
            if (state == DTERM) begin
                d_term   <= diff_x * KD_X;
                prev_err <= err_q;
            end
            if (state == SUM)
                steer <= sat_cmd(p_term + d_term);
            if (load_cmd) begin
                lft <= lft_cmd;
                rht <= rht_cmd;
            end
        end
    end

endmodule

// File: tb/tb_steer_cntrl.sv
// Directed self-checking bench for steer_cntrl: ramp, PD response, saturation, drop, abort, reset.
// Expected values follow the STEER_DTERM_EN setting of the build.
module tb_steer_cntrl;

    logic               clk = 1'b0;
    logic               rst, go, err_vld;
    logic signed [11:0] error;
    logic [10:0]        lft, rht;
    logic               cmd_vld, busy;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef STEER_DTERM_EN
    localparam logic [10:0] P16_L = 11'h2C0, P16_R = 11'h140;
    localparam logic [10:0] DROP_L = 11'h3FF, DROP_R = 11'h5FF;
    localparam logic [10:0] RS16_L = 11'h140, RS16_R = 11'h440;
`else
    localparam logic [10:0] P16_L = 11'h240, P16_R = 11'h1C0;
    localparam logic [10:0] DROP_L = 11'h200, DROP_R = 11'h200;
    localparam logic [10:0] RS16_L = 11'h0C0, RS16_R = 11'h040;
`endif

    always #5 clk = ~clk;

    steer_cntrl dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .err_vld (err_vld),
        .error   (error),
        .lft     (lft),
        .rht     (rht),
        .cmd_vld (cmd_vld),
        .busy    (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a falling edge; returns rising edges from strobe capture to cmd_vld, or -1.
    task automatic applyStimulus(input logic signed [11:0] e, output int lat);
        error   = e;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        lat     = -1;
        for (int c = 1; c <= 20; c++) begin
            if (cmd_vld) begin
                lat = c - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic sendAndCheck(input string tag, input logic signed [11:0] e,
                                input logic [10:0] exp_l, input logic [10:0] exp_r);
        int lat;
        applyStimulus(e, lat);
        checkOutput({tag, "_lat"}, lat, 4);
        checkOutput({tag, "_lft"}, lft, exp_l);
        checkOutput({tag, "_rht"}, rht, exp_r);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, cmd_vld, 0);
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            if (cmd_vld) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          pulses;
        int          exp_spd;
        logic [10:0] cap_l, cap_r;

        rst     = 1'b1;
        go      = 1'b0;
        err_vld = 1'b0;
        error   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_lft", lft, 0);
        checkOutput("rst_rht", rht, 0);
        checkOutput("rst_cmd_vld", cmd_vld, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 10; i++) begin
            exp_spd = (64 * i > 512) ? 512 : 64 * i;
            sendAndCheck($sformatf("ramp%0d", i), 12'sd0, 11'(exp_spd), 11'(exp_spd));
        end

        sendAndCheck("pos16_first", 12'sd16, P16_L, P16_R);
        sendAndCheck("pos16_rep", 12'sd16, 11'h240, 11'h1C0);
        sendAndCheck("neg512_sat", -12'sd512, 11'h5FF, 11'h3FF);

        // A second strobe while busy must vanish without a trace.
        error   = 12'sd0;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        checkOutput("drop_busy", busy, 1);
        @(negedge clk);
        error   = 12'sd100;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        error   = 12'sd0;
        pulses  = 0;
        cap_l   = '0;
        cap_r   = '0;
        for (int c = 0; c < 12; c++) begin
            if (cmd_vld) begin
                pulses++;
                cap_l = lft;
                cap_r = rht;
            end
            @(negedge clk);
        end
        checkOutput("drop_pulses", pulses, 1);
        checkOutput("drop_lft", cap_l, DROP_L);
        checkOutput("drop_rht", cap_r, DROP_R);
        sendAndCheck("after_drop", 12'sd0, 11'h200, 11'h200);

        error   = 12'sd16;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_hold_lft", lft, 11'h200);
        go = 1'b0;
        @(negedge clk);
        checkOutput("abort_lft", lft, 0);
        checkOutput("abort_rht", rht, 0);
        checkOutput("abort_busy", busy, 0);
        countPulses(8, pulses);
        checkOutput("abort_pulses", pulses, 0);
        go = 1'b1;
        @(negedge clk);
        sendAndCheck("restart0", 12'sd0, 11'h040, 11'h040);
        sendAndCheck("restart16", 12'sd16, RS16_L, RS16_R);

        error   = -12'sd100;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_lft", lft, 0);
        checkOutput("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        countPulses(8, pulses);
        checkOutput("rst_mid_pulses", pulses, 0);
        sendAndCheck("post_rst", 12'sd0, 11'h040, 11'h040);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
